// File: rtl/sdram_avmm_arbiter.sv
// sdram_avmm_arbiter: two-master Avalon-MM arbiter onto one SDRAM slave with in-order read return routing.
// Define ARB_FIXED_PRIO_EN to give m0 fixed priority instead of round-robin.
module sdram_avmm_arbiter #(
  parameter int ADDR_W   = 24,
  parameter int DATA_W   = 16,
  parameter int BE_W     = 2,
  parameter int MAX_PEND = 8
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [DATA_W-1:0] m0_writedata,
  input  logic [BE_W-1:0]   m0_byteenable,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_readdatavalid,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m1_writedata,
  input  logic [BE_W-1:0]   m1_byteenable,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_readdatavalid,
  output logic [ADDR_W-1:0] s_address,
  output logic              s_read,
  output logic              s_write,
  output logic [DATA_W-1:0] s_writedata,
  output logic [BE_W-1:0]   s_byteenable,
  input  logic              s_waitrequest,
  input  logic [DATA_W-1:0] s_readdata,
  input  logic              s_readdatavalid,
  output logic [$clog2(MAX_PEND):0] pend_count,
  output logic              err_orphan
);
  localparam int AW = $clog2(MAX_PEND);
  localparam int PW = AW + 1;
  localparam logic [1:0] NONE = 2'd0;
  localparam logic [1:0] G0   = 2'd1;
  localparam logic [1:0] G1   = 2'd2;

  logic [1:0] grant_q, grant_d, pick;
  logic [MAX_PEND-1:0] fifo_q, fifo_d;
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [PW-1:0] pend_q, pend_d;
  logic err_q, err_d;
  logic req0, req1, act, sel1, blocked, g_read, g_write, g_req, accept, push, pop, head;

  always_comb begin
    req0    = m0_read | m0_write;
    req1    = m1_read | m1_write;
    act     = grant_q != NONE;
    sel1    = grant_q == G1;
    blocked = pend_q == PW'(MAX_PEND);
    g_read  = act & (sel1 ? m1_read : m0_read);
    // read wins when a master illegally asserts both
    g_write = act & ~g_read & (sel1 ? m1_write : m0_write);
    g_req   = act & (sel1 ? req1 : req0);
    accept  = ((g_read & ~blocked) | g_write) & ~s_waitrequest;
    push    = accept & g_read;
    pop     = s_readdatavalid & (pend_q != '0);
    head    = fifo_q[rd_q];
    grant_d = (~act | accept) ? pick : g_req ? grant_q : NONE;
    fifo_d  = fifo_q;
    if (push) fifo_d[wr_q] = sel1;
    wr_d    = wr_q + AW'(push);
    rd_d    = rd_q + AW'(pop);
    pend_d  = pend_q + PW'(push) - PW'(pop);
    err_d   = err_q | (s_readdatavalid & (pend_q == '0));
  end

`ifdef ARB_FIXED_PRIO_EN
  always_comb pick = req0 ? G0 : req1 ? G1 : NONE;
`else
  logic ptr_q, ptr_d;
  // ptr_q = 1 favours m1; after an accept the other master is favoured
  always_comb begin
    ptr_d = accept ? ~sel1 : ptr_q;
    pick  = (req0 & req1) ? (ptr_d ? G1 : G0) : req0 ? G0 : req1 ? G1 : NONE;
  end
  always_ff @(posedge clk_clk or negedge reset_reset_n)
    if (!reset_reset_n) ptr_q <= 1'b0;
    else ptr_q <= ptr_d;
`endif

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      grant_q <= NONE;
      fifo_q  <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      pend_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      grant_q <= grant_d;
      fifo_q  <= fifo_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      pend_q  <= pend_d;
      err_q   <= err_d;
    end
  end

  assign s_address        = sel1 ? m1_address : m0_address;
  assign s_writedata      = sel1 ? m1_writedata : m0_writedata;
  assign s_byteenable     = sel1 ? m1_byteenable : m0_byteenable;
  assign s_read           = g_read & ~blocked;
  assign s_write          = g_write;
  assign m0_waitrequest   = (grant_q != G0) | s_waitrequest | (m0_read & blocked);
  assign m1_waitrequest   = (grant_q != G1) | s_waitrequest | (m1_read & blocked);
  assign m0_readdata      = s_readdata;
  assign m1_readdata      = s_readdata;
  assign m0_readdatavalid = pop & ~head;
  assign m1_readdatavalid = pop & head;
  assign pend_count       = pend_q;
  assign err_orphan       = err_q;
endmodule

// File: tb/tb_sdram_avmm_arbiter.sv
// tb_sdram_avmm_arbiter: vector table for arbitration and read routing, plus sequences for full-FIFO, slave stall and orphan returns.
module tb_sdram_avmm_arbiter;
  logic        clk_clk = 1'b0;
  logic        reset_reset_n;
  logic [23:0] m0_address, m1_address, s_address;
  logic        m0_read, m0_write, m1_read, m1_write;
  logic [15:0] m0_writedata, m1_writedata, s_writedata;
  logic [1:0]  m0_byteenable, m1_byteenable, s_byteenable;
  logic        m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid;
  logic [15:0] m0_readdata, m1_readdata, s_readdata;
  logic        s_read, s_write, s_waitrequest, s_readdatavalid, err_orphan;
  logic [3:0]  pend_count;
  int checks = 0;
  int failures = 0;

  typedef struct {
    int m0r, m0w, m1r, m1w, sw, rv, rd;
    int e0w, e1w, esr, esw, ea, e0v, e1v, ep;
  } vec_t;
  vec_t v [14];

  sdram_avmm_arbiter dut (
    .clk_clk(clk_clk), .reset_reset_n(reset_reset_n),
    .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
    .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
    .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
    .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
    .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
    .s_address(s_address), .s_read(s_read), .s_write(s_write),
    .s_writedata(s_writedata), .s_byteenable(s_byteenable),
    .s_waitrequest(s_waitrequest), .s_readdata(s_readdata), .s_readdatavalid(s_readdatavalid),
    .pend_count(pend_count), .err_orphan(err_orphan)
  );

  always #5 clk_clk = ~clk_clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string n, input int a, input int e);
    checks++;
    if (a != e) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", n, a, e);
    end
  endtask

  task automatic tick();
    @(posedge clk_clk);
    #1;
  endtask

  initial begin
    // m0r m0w m1r m1w sw rv rd | e0w e1w esr esw ea e0v e1v ep
    v[0]  = '{0,1,0,1,0,0,0,      1,1,0,0,0,    0,0,0};
    v[1]  = '{0,1,0,1,0,0,0,      0,1,0,1,'h10, 0,0,0};
    v[2]  = '{0,1,0,1,0,0,0,      1,0,0,1,'h20, 0,0,0};
    v[3]  = '{0,1,0,1,0,0,0,      0,1,0,1,'h10, 0,0,0};
    v[4]  = '{0,0,0,0,0,0,0,      1,0,0,0,0,    0,0,0};
    v[5]  = '{1,0,0,0,0,0,0,      1,1,0,0,0,    0,0,0};
    v[6]  = '{1,0,1,0,0,0,0,      0,1,1,0,'h10, 0,0,0};
    v[7]  = '{0,0,1,0,0,0,0,      1,0,1,0,'h20, 0,0,1};
    v[8]  = '{0,0,0,0,0,0,0,      1,0,0,0,0,    0,0,2};
    v[9]  = '{0,0,0,0,0,1,'hAAAA, 1,1,0,0,0,    1,0,2};
    v[10] = '{0,0,0,0,0,0,0,      1,1,0,0,0,    0,0,1};
    v[11] = '{0,0,0,0,0,0,0,      1,1,0,0,0,    0,0,1};
    v[12] = '{0,0,0,0,0,1,'hBBBB, 1,1,0,0,0,    0,1,1};
    v[13] = '{0,0,0,0,0,0,0,      1,1,0,0,0,    0,0,0};

    m0_address = 24'h10; m1_address = 24'h20;
    m0_writedata = 16'h1111; m1_writedata = 16'h2222;
    m0_byteenable = 2'b01; m1_byteenable = 2'b10;
    {m0_read, m0_write, m1_read, m1_write} = '0;
    s_waitrequest = 0; s_readdatavalid = 0; s_readdata = '0;
    reset_reset_n = 0;
    @(negedge clk_clk);
    chk("rst_m0_wait", 32'(m0_waitrequest), 1);
    chk("rst_m1_wait", 32'(m1_waitrequest), 1);
    chk("rst_s_read", 32'(s_read), 0);
    chk("rst_s_write", 32'(s_write), 0);
    chk("rst_pend", 32'(pend_count), 0);
    chk("rst_err", 32'(err_orphan), 0);
    chk("rst_rdv", 32'({m0_readdatavalid, m1_readdatavalid}), 0);
    tick();
    reset_reset_n = 1;

    for (int i = 0; i < 14; i++) begin
      m0_read = v[i].m0r[0]; m0_write = v[i].m0w[0];
      m1_read = v[i].m1r[0]; m1_write = v[i].m1w[0];
      s_waitrequest = v[i].sw[0]; s_readdatavalid = v[i].rv[0]; s_readdata = v[i].rd[15:0];
      @(negedge clk_clk);
      chk($sformatf("v%0d_m0_wait", i), 32'(m0_waitrequest), v[i].e0w);
      chk($sformatf("v%0d_m1_wait", i), 32'(m1_waitrequest), v[i].e1w);
      chk($sformatf("v%0d_s_read", i), 32'(s_read), v[i].esr);
      chk($sformatf("v%0d_s_write", i), 32'(s_write), v[i].esw);
      chk($sformatf("v%0d_m0_rdv", i), 32'(m0_readdatavalid), v[i].e0v);
      chk($sformatf("v%0d_m1_rdv", i), 32'(m1_readdatavalid), v[i].e1v);
      chk($sformatf("v%0d_pend", i), 32'(pend_count), v[i].ep);
      chk($sformatf("v%0d_err", i), 32'(err_orphan), 0);
      if (v[i].esr != 0 || v[i].esw != 0)
        chk($sformatf("v%0d_s_addr", i), 32'(s_address), v[i].ea);
      if (v[i].e0v != 0) chk($sformatf("v%0d_m0_rdata", i), 32'(m0_readdata), v[i].rd);
      if (v[i].e1v != 0) chk($sformatf("v%0d_m1_rdata", i), 32'(m1_readdata), v[i].rd);
      tick();
    end
    {m0_read, m0_write, m1_read, m1_write, s_readdatavalid} = '0;

    // m1 fills the read FIFO; the 9th read stalls while an m0 write still gets through
    m1_read = 1;
    tick();
    for (int k = 0; k < 8; k++) begin
      @(negedge clk_clk);
      chk($sformatf("fill%0d_m1_wait", k), 32'(m1_waitrequest), 0);
      chk($sformatf("fill%0d_s_read", k), 32'(s_read), 1);
      chk($sformatf("fill%0d_pend", k), 32'(pend_count), k);
      tick();
    end
    @(negedge clk_clk);
    chk("full_m1_wait", 32'(m1_waitrequest), 1);
    chk("full_s_read", 32'(s_read), 0);
    chk("full_pend", 32'(pend_count), 8);
    tick();
    m1_read = 0; m0_write = 1;
    tick();
    @(negedge clk_clk);
    chk("full_m0_wait_pre", 32'(m0_waitrequest), 1);
    tick();
    m1_read = 1;
    @(negedge clk_clk);
    chk("full_m0_write_wait", 32'(m0_waitrequest), 0);
    chk("full_m0_s_write", 32'(s_write), 1);
    chk("full_m0_pend", 32'(pend_count), 8);
    tick();
    m0_write = 0; s_readdatavalid = 1;
    @(negedge clk_clk);
    chk("pop_full_m1_wait", 32'(m1_waitrequest), 1);
    chk("pop_full_s_read", 32'(s_read), 0);
    chk("pop_full_m1_rdv", 32'(m1_readdatavalid), 1);
    chk("pop_full_pend", 32'(pend_count), 8);
    tick();
    s_readdatavalid = 0;
    @(negedge clk_clk);
    chk("after_pop_m1_wait", 32'(m1_waitrequest), 0);
    chk("after_pop_s_read", 32'(s_read), 1);
    chk("after_pop_pend", 32'(pend_count), 7);
    tick();
    m1_read = 0;
    for (int k = 0; k < 8; k++) begin
      s_readdatavalid = 1;
      @(negedge clk_clk);
      chk($sformatf("drain%0d_m1_rdv", k), 32'(m1_readdatavalid), 1);
      chk($sformatf("drain%0d_m0_rdv", k), 32'(m0_readdatavalid), 0);
      tick();
    end
    s_readdatavalid = 0;
    @(negedge clk_clk);
    chk("drain_pend", 32'(pend_count), 0);

    // slave stall holds the G0 write and keeps m1 waiting
    m0_write = 1; m1_write = 1; s_waitrequest = 1;
    tick();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk_clk);
      chk($sformatf("stall%0d_m0_wait", k), 32'(m0_waitrequest), 1);
      chk($sformatf("stall%0d_m1_wait", k), 32'(m1_waitrequest), 1);
      chk($sformatf("stall%0d_s_write", k), 32'(s_write), 1);
      chk($sformatf("stall%0d_s_addr", k), 32'(s_address), 'h10);
      chk($sformatf("stall%0d_s_wdata", k), 32'(s_writedata), 'h1111);
      chk($sformatf("stall%0d_s_be", k), 32'(s_byteenable), 1);
      tick();
    end
    s_waitrequest = 0;
    @(negedge clk_clk);
    chk("stall_end_m0_wait", 32'(m0_waitrequest), 0);
    chk("stall_end_m1_wait", 32'(m1_waitrequest), 1);
    tick();
    m0_write = 0;
    @(negedge clk_clk);
    chk("stall_next_m1_wait", 32'(m1_waitrequest), 0);
    chk("stall_next_s_addr", 32'(s_address), 'h20);
    chk("stall_next_s_wdata", 32'(s_writedata), 'h2222);
    tick();
    m1_write = 0;
    tick();

    // orphan return is dropped and sets the sticky flag
    s_readdatavalid = 1;
    @(negedge clk_clk);
    chk("orphan_rdv", 32'({m0_readdatavalid, m1_readdatavalid}), 0);
    chk("orphan_err_pre", 32'(err_orphan), 0);
    tick();
    s_readdatavalid = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_clk);
      chk($sformatf("orphan_err%0d", k), 32'(err_orphan), 1);
      tick();
    end
    reset_reset_n = 0;
    #1;
    chk("orphan_err_rst", 32'(err_orphan), 0);
    tick();
    reset_reset_n = 1;

    // reset with a read outstanding turns its late return into an orphan
    m0_read = 1;
    tick();
    tick();
    m0_read = 0;
    @(negedge clk_clk);
    chk("mid_pend", 32'(pend_count), 1);
    reset_reset_n = 0;
    #1;
    chk("mid_rst_pend", 32'(pend_count), 0);
    chk("mid_rst_m0_wait", 32'(m0_waitrequest), 1);
    tick();
    reset_reset_n = 1;
    s_readdatavalid = 1;
    @(negedge clk_clk);
    chk("late_m0_rdv", 32'(m0_readdatavalid), 0);
    tick();
    s_readdatavalid = 0;
    @(negedge clk_clk);
    chk("late_err", 32'(err_orphan), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sdram_avmm_arbiter.md
Name: sdram_avmm_arbiter

Overview:
- Two-master, one-slave Avalon-MM arbiter sharing the single SDRAM controller slave port.
- Sits between the Nios data master (m0) and a DMA/streaming master (m1) on one side, and the SDRAM controller on the other.
- Round-robin command grant with waitrequest handshake.
- Pipelined-read tracking through an in-order ID FIFO, so each readdatavalid is routed back to the master that issued the read.

Parameters:
- ADDR_W, 24, word address width (13 row + 9 col + 2 bank).
- DATA_W, 16, data width, matching sdram_dq.
- BE_W, 2, byteenable width (DATA_W/8).
- MAX_PEND, 8, maximum outstanding reads; power of two, 2..32.

Ports:
- clk_clk  in  1  system clock.
- reset_reset_n  in  1  asynchronous active-low reset.
- mN_address  in  ADDR_W  master N address (N=0,1).
- mN_read  in  1  master N read request.
- mN_write  in  1  master N write request.
- mN_writedata  in  DATA_W  master N write data.
- mN_byteenable  in  BE_W  master N byte enables.
- mN_waitrequest  out  1  stall to master N.
- mN_readdata  out  DATA_W  read data (both masters see the slave readdata).
- mN_readdatavalid  out  1  read return for master N.
- s_address, s_read, s_write, s_writedata, s_byteenable  out  as above  command to the SDRAM controller.
- s_waitrequest  in  1  slave stall.
- s_readdata  in  DATA_W  slave read data.
- s_readdatavalid  in  1  slave read return.
- pend_count  out  clog2(MAX_PEND)+1  outstanding reads.
- err_orphan  out  1  sticky flag: a read return arrived with no outstanding read.

Behaviour:
- Clock and reset: the single clock is clk_clk. reset_reset_n is asynchronous, active-low.
- Reset values:
  - grant = NONE; round-robin pointer favours m0; ID FIFO empty.
  - pend_count = 0; err_orphan = 0.
  - s_read = s_write = 0.
  - mN_waitrequest = 1; mN_readdatavalid = 0.
- Request: reqN = mN_read | mN_write. Read and write asserted together on one master is illegal; in that case read wins.
- Grant register states: NONE, G0, G1.
  - In NONE: if any reqN, the next state is the granted master. With both requesting, the pointer selects.
  - In Gx with reqx = 0: go to NONE.
- Slave command mux: s_* = fields of the granted master. s_read/s_write are gated to 0 in NONE, and s_read is gated to 0 when read-blocked.
- Read-blocked: registered pend_count == MAX_PEND. Writes are never blocked by this.
- Waitrequest: mN_waitrequest = ~(grant==GN) | s_waitrequest | (mN_read & read-blocked).
- Accept: granted master requesting, not blocked, and s_waitrequest = 0.
- On accept:
  - Pointer moves to favour the other master.
  - If the command is a read, push N into the ID FIFO.
  - Next grant is re-arbitrated in the same cycle (same rule as NONE), so back-to-back commands run at 1 per cycle.
- Read return: on s_readdatavalid with the FIFO non-empty, assert readdatavalid on the head master in the same cycle (combinational) and pop the FIFO.
- Orphan return: s_readdatavalid with the FIFO empty → no readdatavalid to either master; err_orphan sets and stays set until reset.
- pend_count: +1 on read accept, -1 on pop; push and pop in the same cycle leave it unchanged. Full with a same-cycle pop still blocks for that cycle.
- FIFO pointers: clog2(MAX_PEND) bits, natural wrap. Push at full cannot occur because reads are blocked at full.
- Reset mid-operation: outstanding reads are discarded. Late slave returns after reset are orphans and set err_orphan (intended; software clears it by reset).
- Latency: grant is 1 cycle after the first request from NONE. Read data passes through with 0 added cycles.

Optional Feature:
- Macro: ARB_FIXED_PRIO_EN.
- Defined: m0 always wins when both request (Nios latency priority); the pointer logic is removed.
- Undefined: round-robin as above.

Test Plan:
- Reset → mN_waitrequest=1, s_read=0, pend_count=0, err_orphan=0; release → waitrequest stays 1 until the master is granted.
- m0 and m1 both write continuously, s_waitrequest=0 → grants alternate G0,G1,G0,G1; each master gets 1 write per 2 cycles. With ARB_FIXED_PRIO_EN defined, only m0 is accepted until it drops its request.
- m0 reads addr 0x000010 and m1 reads addr 0x000020 back-to-back; slave returns 0xAAAA then 0xBBBB 3 cycles later → m0_readdatavalid with 0xAAAA, then m1_readdatavalid with 0xBBBB; pend_count goes 1,2,1,0.
- m1 issues 8 reads and the slave withholds returns → pend_count=8 and a 9th read stalls; an m0 write in the same window is still accepted; one return → the read is accepted next cycle.
- s_waitrequest=1 for 5 cycles during a G0 write → s_* held stable, grant stays G0, and m1 is not granted until the write is accepted.
- s_readdatavalid pulse with the FIFO empty → no master readdatavalid and err_orphan=1; it stays 1 until reset_reset_n=0.
